// File: rtl/ifetch_queue.sv
// Fetch queue: accepts PC addresses, reads the synchronous instruction ROM and
// buffers {pc, instr} pairs in a small FIFO toward decode, with branch flush.
module ifetch_queue #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clock_in,
    input  logic                       reset,
    input  logic                       pc_valid,
    input  logic [ADDR_W-1:0]          pc_addr,
    output logic                       pc_ready,
    output logic                       imem_en,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       flush,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [DATA_W-1:0]          id_instr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic [ADDR_W-1:0] pc_q;
    logic [CW:0]     pending;
    logic            accept;
    logic            push;
    logic            pop;

    // An in-flight fetch reserves a slot, so a full FIFO never overflows when
    // the ROM word lands; a same-cycle pop earns no credit.
    assign pending   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign pc_ready  = !reset && !flush && (pending < (CW+1)'(DEPTH));
    assign accept    = pc_valid && pc_ready;
    assign imem_en   = accept;
    assign imem_addr = pc_addr[IMEM_AW+1:2];

    assign push      = inflight && !flush;
    assign id_valid  = (count != '0);
    assign pop       = id_valid && id_ready && !flush;
    assign occupancy = count;

    assign head      = mem[rd_ptr];
    assign id_pc     = id_valid ? head.pc    : '0;
    assign id_instr  = id_valid ? head.instr : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            pc_q     <= '0;
        end else if (flush) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept)
                pc_q <= pc_addr;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; outputs are gated by id_valid, so stale
    // entries are never observable and the array can map to plain RAM.
    always_ff @(posedge clock_in) begin
        if (push)
            mem[wr_ptr] <= '{pc: pc_q, instr: imem_rdata};
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised scoreboard bench for ifetch_queue: the driver logs accepted
// fetches, a negedge monitor checks the FIFO outputs against that log.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b1;
    logic        pc_valid = 1'b0;
    logic [31:0] pc_addr  = '0;
    logic        pc_ready;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        flush    = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  occupancy;

    ifetch_queue #(.ADDR_W(32), .DATA_W(32), .IMEM_AW(8), .DEPTH(DEPTH)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .pc_valid   (pc_valid),
        .pc_addr    (pc_addr),
        .pc_ready   (pc_ready),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .occupancy  (occupancy)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rom [256];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    // Synchronous ROM; garbage when not enabled so a mistimed capture shows up.
    always @(posedge clock_in) imem_rdata <= imem_en ? rom[imem_addr] : $urandom;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: an entry accepted in cycle A is visible to decode from cycle
    // A+2 on; everything accepted before this cycle holds a slot.
    always @(negedge clock_in) begin
        int vis;
        int tot;
        if (reset) begin
            check("rst_id_valid", id_valid, 0);
            check("rst_occupancy", occupancy, 0);
            check("rst_pc_ready", pc_ready, 0);
            exp_q.delete();
        end else begin
            vis = 0;
            tot = 0;
            foreach (exp_q[i]) begin
                if (exp_q[i].acc + 2 <= cyc) vis++;
                if (exp_q[i].acc < cyc) tot++;
            end
            check("occupancy", occupancy, vis);
            check("id_valid", id_valid, vis != 0);
            check("pc_ready", pc_ready, !flush && tot < DEPTH);
            check("imem_en", imem_en, pc_valid && !flush && tot < DEPTH);
            if (imem_en)
                check("imem_addr", imem_addr, pc_addr[9:2]);
            if (vis != 0) begin
                check("id_pc", id_pc, exp_q[0].pc);
                check("id_instr", id_instr, exp_q[0].instr);
            end
            if (flush) begin
                while (exp_q.size() > 0 && exp_q[0].acc < cyc)
                    void'(exp_q.pop_front());
            end else if (vis != 0 && id_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic drive(input logic v, input logic [31:0] a, input logic r, input logic f);
        pc_valid = v;
        pc_addr  = a;
        id_ready = r;
        flush    = f;
        @(negedge clock_in);
        if (!reset && pc_valid && pc_ready)
            exp_q.push_back('{pc: a, instr: rom[a[9:2]], acc: cyc});
        @(posedge clock_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = (i < 16) ? 32'h1000 + i : $urandom;

        #1;
        check("reset_pc_ready", pc_ready, 0);
        check("reset_id_valid", id_valid, 0);
        check("reset_occupancy", occupancy, 0);
        check("reset_id_pc", id_pc, 0);
        check("reset_id_instr", id_instr, 0);
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;

        // Stream of three sequential fetches.
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        idle(4);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: fills to DEPTH, then drains in order.
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h40 + 4 * i, 1'b0, 1'b0);
        check("bp_occupancy", occupancy, DEPTH);
        check("bp_pc_ready", pc_ready, 0);
        idle(6);
        check("bp_drained", occupancy, 0);

        // Full FIFO, single pop, exactly one refill.
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h80 + 4 * i, 1'b0, 1'b0);
        drive(1'b1, 32'hA0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hA4 + 4 * i, 1'b0, 1'b0);
        check("full_pop_occupancy", occupancy, DEPTH);
        idle(6);

        // Flush with three buffered entries and one in flight.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 4 * i, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("flush_occupancy", occupancy, 0);
        check("flush_id_valid", id_valid, 0);
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_pc", id_pc, 32'h40);
        check("post_flush_instr", id_instr, rom[16]);
        idle(3);

        // Ten fetches with alternating decode readiness across pointer wrap.
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h200 + 4 * i + (i % 4), i[0], 1'b0);
        idle(8);
        check("wrap_drained", exp_q.size(), 0);

        random_run(400);
        idle(8);

        // Asynchronous reset between clock edges.
        random_run(6);
        pc_valid = 1'b1;
        id_ready = 1'b0;
        flush    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_id_valid", id_valid, 0);
        check("async_occupancy", occupancy, 0);
        check("async_pc_ready", pc_ready, 0);
        pc_valid = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;

        random_run(150);
        idle(8);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
